// File: rtl/oci_trace_pkg.sv
// Shared OCI trace definitions: DCT packing geometry, symbol encodings, unpacker states.
// Latency: none, declarations only; backpressure: not applicable.
package oci_trace_pkg;

    localparam int DCT_SYM_W   = 2;
    localparam int DCT_SLOTS   = 15;
    localparam int DCT_COUNT_W = 4;

    typedef logic [DCT_SYM_W-1:0] dct_sym_t;

    localparam dct_sym_t DCT_SYM_IDLE   = 2'b00;
    localparam dct_sym_t DCT_SYM_DATA   = 2'b01;
    localparam dct_sym_t DCT_SYM_ADDR   = 2'b10;
    localparam dct_sym_t DCT_SYM_MARKER = 2'b11;

    typedef enum logic {
        DCT_ST_IDLE  = 1'b0,
        DCT_ST_DRAIN = 1'b1
    } dct_state_t;

endpackage

// File: rtl/oci_dct_shift_reg.sv
// Holds one packed DCT word, shifting right by one symbol per transfer, with a remaining-symbol counter.
// Latency: load/shift visible one cycle after the edge; backpressure: holds contents while shift is low.
module oci_dct_shift_reg
    import oci_trace_pkg::*;
#(
    parameter int SYM_W   = DCT_SYM_W,
    parameter int SLOTS   = DCT_SLOTS,
    parameter int COUNT_W = DCT_COUNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [SYM_W*SLOTS-1:0]   load_data,
    input  logic [COUNT_W-1:0]       load_count,
    input  logic                     shift,
    input  logic                     clear,
    output logic [SYM_W-1:0]         head,
    output logic [COUNT_W-1:0]       remaining
);

    localparam int BUF_W = SYM_W * SLOTS;

    logic [BUF_W-1:0]   sr;
    logic [COUNT_W-1:0] rem;

    // A load in the same cycle as the final shift replaces the word outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr  <= '0;
            rem <= '0;
        end else if (load) begin
            sr  <= load_data;
            rem <= load_count;
        end else if (clear) begin
            rem <= '0;
        end else if (shift && rem != '0) begin
            sr  <= sr >> SYM_W;
            rem <= rem - COUNT_W'(1);
        end
    end

    assign head      = sr[SYM_W-1:0];
    assign remaining = rem;

endmodule

// File: rtl/oci_dct_unpacker.sv
// Serialises packed DCT words (slot 0 first) into a one-symbol-per-cycle valid/ready stream.
// Latency: first symbol the cycle after accept, no bubble between words; backpressure: output holds while sym_ready is low.
module oci_dct_unpacker
    import oci_trace_pkg::*;
#(
    parameter int SYM_W   = DCT_SYM_W,
    parameter int SLOTS   = DCT_SLOTS,
    parameter int COUNT_W = DCT_COUNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SYM_W*SLOTS-1:0]   in_buffer,
    input  logic [COUNT_W-1:0]       in_count,
    output logic                     sym_valid,
    input  logic                     sym_ready,
    output logic [SYM_W-1:0]         sym_data,
    output logic                     sym_last,
    output logic                     overflow_err,
    output logic [15:0]              words_accepted
);

    localparam logic [COUNT_W-1:0] SLOTS_C = COUNT_W'(SLOTS);
    localparam logic [COUNT_W-1:0] ONE_C   = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] TWO_C   = COUNT_W'(2);

    dct_state_t         state;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] clamped;
    logic               accept;
    logic               xfer;
    logic               drain_flush;
    logic               rem_one;
    logic               over;

    assign rem_one     = (remaining == ONE_C);
    assign drain_flush = flush && (state == DCT_ST_DRAIN);
    assign over        = (in_count > SLOTS_C);
    assign clamped     = over ? SLOTS_C : in_count;

    // Combinational path: a new word may land on the same edge the last symbol leaves.
    assign in_ready = (state == DCT_ST_IDLE) ||
                      ((state == DCT_ST_DRAIN) && rem_one && sym_ready && !flush);
    assign accept   = in_valid && in_ready;
    assign xfer     = sym_valid && sym_ready;

    oci_dct_shift_reg #(
        .SYM_W   (SYM_W),
        .SLOTS   (SLOTS),
        .COUNT_W (COUNT_W)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_data  (in_buffer),
        .load_count (clamped),
        .shift      (xfer),
        .clear      (drain_flush),
        .head       (sym_data),
        .remaining  (remaining)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= DCT_ST_IDLE;
            sym_valid <= 1'b0;
            sym_last  <= 1'b0;
        end else if (accept) begin
            if (clamped == '0) begin
                state     <= DCT_ST_IDLE;
                sym_valid <= 1'b0;
                sym_last  <= 1'b0;
            end else begin
                state     <= DCT_ST_DRAIN;
                sym_valid <= 1'b1;
                sym_last  <= (clamped == ONE_C);
            end
        end else if (drain_flush) begin
            state     <= DCT_ST_IDLE;
            sym_valid <= 1'b0;
            sym_last  <= 1'b0;
        end else if (xfer) begin
            if (rem_one) begin
                state     <= DCT_ST_IDLE;
                sym_valid <= 1'b0;
                sym_last  <= 1'b0;
            end else begin
                sym_last  <= (remaining == TWO_C);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_err   <= 1'b0;
            words_accepted <= '0;
        end else if (accept) begin
            overflow_err   <= overflow_err | over;
            words_accepted <= words_accepted + 16'd1;
        end
    end

endmodule

// File: tb/tb_oci_dct_unpacker.sv
// Self-checking bench for oci_dct_unpacker: vector table, corner sequences, randomized scoreboard run.
module tb_oci_dct_unpacker;
    import oci_trace_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_buffer = '0;
    logic [3:0]  in_count = '0;
    logic        sym_valid;
    logic        sym_ready = 1'b0;
    logic [1:0]  sym_data;
    logic        sym_last;
    logic        overflow_err;
    logic [15:0] words_accepted;

    logic        b_flush = 1'b0;
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [23:0] b_in_buffer = '0;
    logic [3:0]  b_in_count = '0;
    logic        b_sym_valid;
    logic        b_sym_ready = 1'b0;
    logic [1:0]  b_sym_data;
    logic        b_sym_last;
    logic        b_overflow_err;
    logic [15:0] b_words_accepted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    oci_dct_unpacker u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_buffer(in_buffer), .in_count(in_count),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data), .sym_last(sym_last),
        .overflow_err(overflow_err), .words_accepted(words_accepted)
    );

    oci_dct_unpacker #(.SLOTS(12)) u_dut12 (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_buffer(b_in_buffer), .in_count(b_in_count),
        .sym_valid(b_sym_valid), .sym_ready(b_sym_ready), .sym_data(b_sym_data), .sym_last(b_sym_last),
        .overflow_err(b_overflow_err), .words_accepted(b_words_accepted)
    );

    typedef struct {
        logic [29:0] bufv;
        logic [3:0]  cnt;
        int          exp_n;
        dct_sym_t    exp_first;
        dct_sym_t    exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called right after a rising edge; returns right after the accepting edge.
    task automatic present_main(input logic [29:0] b, input logic [3:0] c);
        in_buffer = b;
        in_count  = c;
        in_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) break;
            if (i == 49) chk("in_ready_timeout", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic collect_main(output int n, output dct_sym_t first, output dct_sym_t last_sym,
                                output int nlast, output logic last_ok);
        n = 0; nlast = 0; last_ok = 1'b0; first = '0; last_sym = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!sym_valid) break;
            if (n == 0) first = sym_data;
            last_sym = sym_data;
            last_ok  = sym_last;
            if (sym_last) nlast++;
            n++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_random(input int nw, input bit full);
        dct_sym_t q[$];
        bit       ql[$];
        int       issued = 0;
        bit       stalled = 0;
        dct_sym_t pd = '0;
        logic     pl = 1'b0;
        bit       acc;
        for (int cy = 0; cy < 20000; cy++) begin
            if (!in_valid && issued < nw && $urandom_range(0, 3) != 0) begin
                in_buffer = 30'($urandom());
                in_count  = full ? 4'd15 : 4'($urandom_range(0, 15));
                in_valid  = 1'b1;
                issued++;
            end
            sym_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (sym_valid) begin
                if (stalled) begin
                    chk("stall_data", 32'(sym_data), 32'(pd));
                    chk("stall_last", 32'(sym_last), 32'(pl));
                end
                if (sym_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_sym", 32'(sym_valid), 32'd0);
                    end else begin
                        chk("rnd_data", 32'(sym_data), 32'(q[0]));
                        chk("rnd_last", 32'(sym_last), 32'(ql[0]));
                        void'(q.pop_front());
                        void'(ql.pop_front());
                    end
                end
            end else if (stalled) begin
                chk("stall_valid", 32'(sym_valid), 32'd1);
            end
            stalled = sym_valid && !sym_ready;
            pd  = sym_data;
            pl  = sym_last;
            acc = in_valid && in_ready;
            if (acc) begin
                for (int k = 0; k < int'(in_count); k++) begin
                    q.push_back(in_buffer[k*2 +: 2]);
                    ql.push_back(k == int'(in_count) - 1);
                end
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            if (issued == nw && !in_valid && q.size() == 0) break;
        end
        @(negedge clk);
        chk("rnd_idle_after", 32'(sym_valid), 32'd0);
        chk("rnd_queue_empty", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t     vecs[7];
        int       n, nlast;
        dct_sym_t first, last_sym;
        logic     last_ok;
        int       ev[6];
        int       ed[5];
        int       er[6];

        vecs[0] = '{30'h0000_00E4, 4'd4,  4,  DCT_SYM_IDLE,   DCT_SYM_MARKER};
        vecs[1] = '{30'h3FFF_FFFF, 4'd15, 15, DCT_SYM_MARKER, DCT_SYM_MARKER};
        vecs[2] = '{30'h1234_5678, 4'd0,  0,  DCT_SYM_IDLE,   DCT_SYM_IDLE};
        vecs[3] = '{30'h0000_0003, 4'd1,  1,  DCT_SYM_MARKER, DCT_SYM_MARKER};
        vecs[4] = '{30'h2000_0001, 4'd15, 15, DCT_SYM_DATA,   DCT_SYM_ADDR};
        vecs[5] = '{30'h0000_0006, 4'd2,  2,  DCT_SYM_ADDR,   DCT_SYM_DATA};
        vecs[6] = '{30'h0000_0300, 4'd5,  5,  DCT_SYM_IDLE,   DCT_SYM_MARKER};
        ev = '{1, 1, 1, 1, 1, 0};
        ed = '{1, 2, 1, 2, 3};
        er = '{0, 1, 0, 0, 1, 1};

        // Reset values while reset is held
        #3;
        chk("rst_sym_valid", 32'(sym_valid), 32'd0);
        chk("rst_sym_last", 32'(sym_last), 32'd0);
        chk("rst_sym_data", 32'(sym_data), 32'd0);
        chk("rst_overflow", 32'(overflow_err), 32'd0);
        chk("rst_words", 32'(words_accepted), 32'd0);
        chk("rst_b_overflow", 32'(b_overflow_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Vector table, one word at a time, sink always ready
        sym_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            present_main(vecs[i].bufv, vecs[i].cnt);
            collect_main(n, first, last_sym, nlast, last_ok);
            chk($sformatf("vec%0d_count", i), 32'(n), 32'(vecs[i].exp_n));
            if (vecs[i].exp_n > 0) begin
                chk($sformatf("vec%0d_first", i), 32'(first), 32'(vecs[i].exp_first));
                chk($sformatf("vec%0d_lastsym", i), 32'(last_sym), 32'(vecs[i].exp_last));
                chk($sformatf("vec%0d_nlast", i), 32'(nlast), 32'd1);
                chk($sformatf("vec%0d_last_on_final", i), 32'(last_ok), 32'd1);
            end
        end
        chk("table_words", 32'(words_accepted), 32'd7);

        // Back-to-back: A (2 symbols) then B (3 symbols) with no gap
        in_buffer = 30'h0000_0009; in_count = 4'd2; in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_buffer = 30'h0000_0039; in_count = 4'd3;
        for (int c = 0; c < 6; c++) begin
            bit acc;
            @(negedge clk);
            chk($sformatf("b2b_valid%0d", c), 32'(sym_valid), 32'(ev[c]));
            if (c < 5) chk($sformatf("b2b_data%0d", c), 32'(sym_data), 32'(ed[c]));
            chk($sformatf("b2b_in_ready%0d", c), 32'(in_ready), 32'(er[c]));
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        chk("b2b_words", 32'(words_accepted), 32'd9);

        // Flush after two of six symbols
        present_main(30'h0000_00E4, 4'd6);
        @(negedge clk);
        chk("flush_sym0", 32'(sym_data), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush_sym1", 32'(sym_data), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid_after", 32'(sym_valid), 32'd0);
        chk("flush_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        present_main(30'h0000_0036, 4'd3);
        flush = 1'b0;
        collect_main(n, first, last_sym, nlast, last_ok);
        chk("post_flush_count", 32'(n), 32'd3);
        chk("post_flush_first", 32'(first), 32'd2);
        chk("post_flush_last", 32'(last_sym), 32'd3);
        chk("post_flush_words", 32'(words_accepted), 32'd11);

        // Reset in the middle of a drain
        present_main(30'h3FFF_FFFF, 4'd10);
        repeat (3) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(sym_valid), 32'd0);
        chk("mid_rst_last", 32'(sym_last), 32'd0);
        chk("mid_rst_data", 32'(sym_data), 32'd0);
        chk("mid_rst_words", 32'(words_accepted), 32'd0);
        chk("mid_rst_overflow", 32'(overflow_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Full word under 50% backpressure, then randomized traffic
        run_random(1, 1'b1);
        run_random(300, 1'b0);
        chk("rnd_words", 32'(words_accepted), 32'd301);
        chk("rnd_overflow", 32'(overflow_err), 32'd0);

        // 12-slot instance: over-count word is clamped and flagged
        b_sym_ready = 1'b1;
        b_in_buffer = 24'($urandom());
        b_in_count  = 4'd14;
        b_in_valid  = 1'b1;
        @(negedge clk);
        chk("s12_in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!b_sym_valid) break;
            if (n < 12) chk($sformatf("s12_sym%0d", n), 32'(b_sym_data), 32'(b_in_buffer[n*2 +: 2]));
            n++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("s12_count", 32'(n), 32'd12);
        chk("s12_overflow", 32'(b_overflow_err), 32'd1);
        b_in_buffer = 24'h00_0FFF;
        b_in_count  = 4'd5;
        b_in_valid  = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        @(negedge clk);
        chk("s12_flush_valid", 32'(b_sym_valid), 32'd0);
        chk("s12_overflow_sticky", 32'(b_overflow_err), 32'd1);
        chk("s12_words", 32'(b_words_accepted), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
